vga_layer_arbiter: RTL

Per-pixel arbiter between the VGA timing controller and the game's object drawers (frog, cars, logs, background). Each cycle it picks the highest-priority layer that is drawing the current pixel and drives a registered RGB value to the VGA colour inputs. Layer priority comes from a shadowed configuration that commits only at start of frame. It also records a per-frame collision mask between the player layer (layer 0) and every other layer.

---
 rtl/vga_layer_arbiter_if.sv | 30 +++
 rtl/vga_layer_arbiter.sv | 102 ++++++++++
 2 files changed

// File: rtl/vga_layer_arbiter_if.sv
// Pixel-path bundle between the VGA timing controller, the object drawers and the layer arbiter.
// The arbiter takes the slave side; the drawers and the timing controller take the master side.
interface vga_layer_arbiter_if #(
    parameter int N_LAYERS = 4,
    parameter int RANK_W   = 3
);
    logic                         iStartOfFrame;
    logic                         iPixelValid;
    logic [N_LAYERS-1:0]          iDrawReq;
    logic [24*N_LAYERS-1:0]       iRGB;
    logic [23:0]                  iBgRGB;
    logic [RANK_W*N_LAYERS-1:0]   iPrioCfg;
    logic                         iCfgWrite;
    logic [7:0]                   oRed;
    logic [7:0]                   oGreen;
    logic [7:0]                   oBlue;
    logic [RANK_W-1:0]            oWinner;
    logic [N_LAYERS-1:0]          oCollision;
    logic                         oCollisionValid;

    modport master (
        output iStartOfFrame, iPixelValid, iDrawReq, iRGB, iBgRGB, iPrioCfg, iCfgWrite,
        input  oRed, oGreen, oBlue, oWinner, oCollision, oCollisionValid
    );

    modport slave (
        input  iStartOfFrame, iPixelValid, iDrawReq, iRGB, iBgRGB, iPrioCfg, iCfgWrite,
        output oRed, oGreen, oBlue, oWinner, oCollision, oCollisionValid
    );
endinterface

// File: rtl/vga_layer_arbiter.sv
// Per-pixel layer arbiter: registered RGB from the highest-priority drawing layer,
// frame-shadowed priority ranks, and a per-frame player collision mask.
module vga_layer_arbiter #(
    parameter int N_LAYERS = 4,
    parameter int RANK_W   = 3
) (
    input logic                  iCLK,
    input logic                  iRST_N,
    vga_layer_arbiter_if.slave   bus
);
    localparam logic [RANK_W-1:0] BLANK_IDX = RANK_W'(N_LAYERS);
    localparam int                CFG_W     = RANK_W * N_LAYERS;

    function automatic logic [CFG_W-1:0] identity_ranks();
        logic [CFG_W-1:0] r;
        r = '0;
        for (int k = 0; k < N_LAYERS; k++) begin
            r[RANK_W*k +: RANK_W] = RANK_W'(k);
        end
        return r;
    endfunction

    logic [CFG_W-1:0]     pending_rank;
    logic [CFG_W-1:0]     active_rank;
    logic [23:0]          rgb_q;
    logic [RANK_W-1:0]    winner_q;
    logic [N_LAYERS-1:0]  coll_acc;
    logic [N_LAYERS-1:0]  coll_q;
    logic                 coll_valid_q;

    logic                 win_found;
    logic [RANK_W-1:0]    win_idx;
    logic [RANK_W-1:0]    win_rank;
    logic [23:0]          win_rgb;
    logic [23:0]          next_rgb;
    logic [RANK_W-1:0]    next_winner;
    logic [N_LAYERS-1:0]  hits;

    // Strict less-than while scanning upward leaves ties with the lower layer index.
    always_comb begin
        win_found = 1'b0;
        win_idx   = BLANK_IDX;
        win_rank  = '0;
        win_rgb   = bus.iBgRGB;
        for (int k = 0; k < N_LAYERS; k++) begin
            if (bus.iDrawReq[k] &&
                (!win_found || (active_rank[RANK_W*k +: RANK_W] < win_rank))) begin
                win_found = 1'b1;
                win_idx   = RANK_W'(k);
                win_rank  = active_rank[RANK_W*k +: RANK_W];
                win_rgb   = bus.iRGB[24*k +: 24];
            end
        end
    end

    always_comb begin
        next_rgb    = 24'h0;
        next_winner = BLANK_IDX;
        if (bus.iPixelValid) begin
            next_rgb    = win_rgb;
            next_winner = win_idx;
        end
        hits = '0;
        if (bus.iPixelValid && bus.iDrawReq[0]) begin
            hits = {bus.iDrawReq[N_LAYERS-1:1], 1'b0};
        end
    end

    // Hits seen on the start-of-frame cycle still belong to the frame being closed.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            pending_rank <= identity_ranks();
            active_rank  <= identity_ranks();
            rgb_q        <= 24'h0;
            winner_q     <= BLANK_IDX;
            coll_acc     <= '0;
            coll_q       <= '0;
            coll_valid_q <= 1'b0;
        end else begin
            rgb_q        <= next_rgb;
            winner_q     <= next_winner;
            coll_valid_q <= bus.iStartOfFrame;
            if (bus.iCfgWrite) begin
                pending_rank <= bus.iPrioCfg;
            end
            if (bus.iStartOfFrame) begin
                active_rank <= bus.iCfgWrite ? bus.iPrioCfg : pending_rank;
                coll_q      <= coll_acc | hits;
                coll_acc    <= '0;
            end else begin
                coll_acc    <= coll_acc | hits;
            end
        end
    end

    assign bus.oRed            = rgb_q[23:16];
    assign bus.oGreen          = rgb_q[15:8];
    assign bus.oBlue           = rgb_q[7:0];
    assign bus.oWinner         = winner_q;
    assign bus.oCollision      = coll_q;
    assign bus.oCollisionValid = coll_valid_q;
endmodule
